// File: rtl/sha_custom_pkg.sv
// Shared encodings and state type for the custom-opcode SHA sequencer.
package sha_custom_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] OPC_CUSTOM1 = 7'b0101011;
  localparam logic [6:0] OPC_CUSTOM2 = 7'b1011011;

  localparam logic [2:0] F3_LOAD_TEMP = 3'd0;
  localparam logic [2:0] F3_PLUS1     = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sha_custom_sequencer_timeout.sv
// Saturating WAIT-cycle counter; expire flags the last permitted cycle.
module sha_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (en && cnt_q != LAST) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/sha_custom_sequencer.sv
// Multi-cycle sequencer for custom-0/1/2 opcodes: decode pulses, SHA launch,
// pipeline stall, flush abort, timeout and illegal-encoding reporting.
module sha_custom_sequencer
  import sha_custom_pkg::*;
#(
  parameter int unsigned NUM_MODES      = 4,
  parameter int unsigned MODE_W         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              flush,
  input  logic              sha_done,
  input  logic              err_clear,
  output logic              stall,
  output logic              start_sha,
  output logic              sha_abort,
  output logic [MODE_W-1:0] sel_mux_res_sha,
  output logic              load_temp,
  output logic              plus1,
  output logic              op_done,
  output logic              illegal_op,
  output logic              timeout_err,
  output logic              busy
);

  state_e            state_q;
  logic [MODE_W-1:0] sel_q;
  logic              load_temp_q, plus1_q, illegal_q, abort_q, op_done_q, terr_q;

  logic accept, is_c0, is_c1, is_c2, mode_ok, launch, expire, timeout_evt;

  assign accept  = (state_q == IDLE) && instr_valid && !flush;
  assign is_c0   = (opcode == OPC_CUSTOM0);
  assign is_c1   = (opcode == OPC_CUSTOM1);
  assign is_c2   = (opcode == OPC_CUSTOM2);
  assign mode_ok = ({1'b0, funct3} < 4'(NUM_MODES));
  assign launch  = accept && is_c1 && mode_ok;

  // A flush wins over both completion and expiry in the same WAIT cycle.
  assign timeout_evt = (state_q == WAIT) && !flush && !sha_done && expire;

  sha_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ISSUE),
    .en     (state_q == WAIT),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      load_temp_q <= 1'b0;
      plus1_q     <= 1'b0;
      illegal_q   <= 1'b0;
      abort_q     <= 1'b0;
      op_done_q   <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      load_temp_q <= 1'b0;
      plus1_q     <= 1'b0;
      illegal_q   <= 1'b0;
      abort_q     <= 1'b0;
      op_done_q   <= 1'b0;
      if (timeout_evt)    terr_q <= 1'b1;
      else if (err_clear) terr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_c0) begin
              if (funct3 == F3_LOAD_TEMP)  load_temp_q <= 1'b1;
              else if (funct3 == F3_PLUS1) plus1_q     <= 1'b1;
              else                         illegal_q   <= 1'b1;
            end else if (is_c1) begin
              if (mode_ok) begin
                sel_q   <= funct3[MODE_W-1:0];
                state_q <= ISSUE;
              end else begin
                illegal_q <= 1'b1;
              end
            end else if (is_c2) begin
              illegal_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (flush) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else if (sha_done) begin
            state_q   <= DONE;
            op_done_q <= 1'b1;
          end else if (expire) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // start_sha is gated by flush so a flush landing in ISSUE never launches.
  assign start_sha       = (state_q == ISSUE) && !flush;
  assign stall           = (state_q == ISSUE) || (state_q == WAIT) || launch;
  assign busy            = (state_q != IDLE);
  assign sha_abort       = abort_q;
  assign sel_mux_res_sha = sel_q;
  assign load_temp       = load_temp_q;
  assign plus1           = plus1_q;
  assign op_done         = op_done_q;
  assign illegal_op      = illegal_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_sha_custom_sequencer.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor pops and compares.
module tb_sha_custom_sequencer;

  localparam logic [6:0] C0 = 7'b0001011;
  localparam logic [6:0] C1 = 7'b0101011;
  localparam logic [6:0] C2 = 7'b1011011;

  localparam logic [5:0] LT = 6'b100000;
  localparam logic [5:0] P1 = 6'b010000;
  localparam logic [5:0] IL = 6'b001000;
  localparam logic [5:0] ST = 6'b000100;
  localparam logic [5:0] AB = 6'b000010;
  localparam logic [5:0] OD = 6'b000001;

  logic       clk = 1'b0;
  logic       rst, instr_valid, flush, sha_done, err_clear;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       stall, start_sha, sha_abort, load_temp, plus1, op_done, illegal_op;
  logic       timeout_err, busy;
  logic [1:0] sel_mux_res_sha;

  sha_custom_sequencer #(
    .NUM_MODES      (3),
    .MODE_W         (2),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid     (instr_valid),
    .opcode          (opcode),
    .funct3          (funct3),
    .flush           (flush),
    .sha_done        (sha_done),
    .err_clear       (err_clear),
    .stall           (stall),
    .start_sha       (start_sha),
    .sha_abort       (sha_abort),
    .sel_mux_res_sha (sel_mux_res_sha),
    .load_temp       (load_temp),
    .plus1           (plus1),
    .op_done         (op_done),
    .illegal_op      (illegal_op),
    .timeout_err     (timeout_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] p;
    logic [1:0] sel;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  T;

  logic [5:0] mon_p;
  ev_t        mon_e;

  // Monitor: every pulse the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    mon_p = {load_temp, plus1, illegal_op, start_sha, sha_abort, op_done};
    if (mon_p != 6'b0) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b sel=%0d", cyc, mon_p, sel_mux_res_sha);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.p != mon_p || mon_e.sel != sel_mux_res_sha) begin
          fails++;
          $display("FAIL pulse_event got cyc=%0d p=%b sel=%0d exp cyc=%0d p=%b sel=%0d",
                   cyc, mon_p, sel_mux_res_sha, mon_e.cyc, mon_e.p, mon_e.sel);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    opcode      = 7'd0;
    funct3      = 3'd0;
    flush       = 1'b0;
    sha_done    = 1'b0;
    err_clear   = 1'b0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3);
    instr_valid = 1'b1;
    opcode      = op;
    funct3      = f3;
  endtask

  task automatic push(input int c, input logic [5:0] p, input logic [1:0] s);
    q.push_back('{cyc: c, p: p, sel: s});
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_sel", sel_mux_res_sha, 0);
    chk("rst_pulses", {load_temp, plus1, illegal_op, start_sha, sha_abort, op_done}, 0);
    tick(); rst = 1'b0;
    tick();

    // Custom-0 back to back
    tick(); T = cyc; drive(C0, 3'd0); push(T + 1, LT, 2'd0);
    @(negedge clk); chk("c0_stall0", stall, 0);
    tick(); drive(C0, 3'd1); push(T + 2, P1, 2'd0);
    @(negedge clk); chk("c0_stall1", stall, 0);
    tick(); idle();
    @(negedge clk); chk("c0_stall2", stall, 0);

    // Custom-1 mode 2, done six cycles after start, stray instr in WAIT
    tick(); T = cyc; drive(C1, 3'd2); push(T + 1, ST, 2'd2); push(T + 8, OD, 2'd2);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        tick(); idle();
        if (k == 3) drive(C0, 3'd0);
        if (k == 7) sha_done = 1'b1;
      end
      @(negedge clk);
      chk("c1_stall", stall, (k <= 7) ? 1 : 0);
      if (k >= 1) chk("c1_busy", busy, (k <= 8) ? 1 : 0);
    end

    // Timeout after 16 WAIT cycles, then err_clear
    tick(); T = cyc; drive(C1, 3'd1); push(T + 1, ST, 2'd1); push(T + 18, AB, 2'd1);
    for (int k = 1; k <= 21; k++) begin
      tick(); idle();
      if (k == 20) err_clear = 1'b1;
      @(negedge clk);
      if (k == 17) begin chk("to_terr_pre", timeout_err, 0); chk("to_busy_pre", busy, 1); end
      if (k == 18) begin chk("to_terr_set", timeout_err, 1); chk("to_busy_post", busy, 0); end
      if (k == 20) chk("to_terr_hold", timeout_err, 1);
      if (k == 21) chk("to_terr_clr", timeout_err, 0);
    end

    // Flush and done in same WAIT cycle, new accept right after
    tick(); T = cyc; drive(C1, 3'd0);
    push(T + 1, ST, 2'd0); push(T + 5, AB, 2'd0); push(T + 6, P1, 2'd0);
    for (int k = 1; k <= 6; k++) begin
      tick(); idle();
      if (k == 4) begin flush = 1'b1; sha_done = 1'b1; end
      if (k == 5) drive(C0, 3'd1);
      @(negedge clk);
      if (k == 4) chk("fl_stall", stall, 1);
      if (k == 5) chk("fl_busy", busy, 0);
    end

    // Flush in ISSUE suppresses start; flush blocks acceptance
    tick(); T = cyc; drive(C1, 3'd2); push(T + 2, AB, 2'd2);
    tick(); idle(); flush = 1'b1;
    @(negedge clk); chk("fi_start", start_sha, 0);
    tick(); idle(); flush = 1'b1; drive(C0, 3'd0);
    tick(); idle();
    @(negedge clk); chk("fi_busy", busy, 0);

    // Illegal encodings and a foreign opcode
    tick(); T = cyc; drive(C1, 3'd3); push(T + 1, IL, 2'd2);
    tick(); drive(C2, 3'd1); push(T + 2, IL, 2'd2);
    @(negedge clk); chk("il_busy", busy, 0);
    tick(); drive(C0, 3'd5); push(T + 3, IL, 2'd2);
    tick(); drive(7'b0110011, 3'd0);
    tick(); idle();
    @(negedge clk); chk("il_busy2", busy, 0);
    tick();

    // Reset during WAIT, later done ignored
    tick(); T = cyc; drive(C1, 3'd1); push(T + 1, ST, 2'd1);
    tick(); idle();
    tick();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; sha_done = 1'b1;
    @(negedge clk);
    chk("rs_sel", sel_mux_res_sha, 0);
    chk("rs_busy", busy, 0);
    chk("rs_stall", stall, 0);
    tick(); sha_done = 1'b1;
    tick(); idle();
    repeat (3) tick();
    @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
